// File: rtl/cwc_pkg.sv
// Shared types and constants for the debug-probe capture sequencer.
// The sample layout is fixed as {probe0, probe1, probe2}.
package cwc_pkg;

  localparam int SAMPLE_W = 25;

  localparam int P0_BIT = 24;
  localparam int P1_MSB = 23;
  localparam int P1_LSB = 16;
  localparam int P2_MSB = 15;
  localparam int P2_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    POST,
    DONE
  } cwc_state_e;

endpackage

// File: rtl/cwc_trig_match.sv
// Masked trigger comparator: only bits set in mask take part in the compare.
module cwc_trig_match
  import cwc_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] mask,
  input  logic [SAMPLE_W-1:0] value,
  output logic                hit
);

  assign hit = ((sample ^ value) & mask) == '0;

endmodule

// File: rtl/cwc_capture_ctrl.sv
// Capture sequencer: writes probe samples into a circular capture RAM with a
// programmable pre-trigger window and reports the trigger and window start.
module cwc_capture_ctrl
  import cwc_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                probe0,
  input  logic [7:0]          probe1,
  input  logic [15:0]         probe2,
  input  logic                arm,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   pretrig,
  input  logic [SAMPLE_W-1:0] trig_mask,
  input  logic [SAMPLE_W-1:0] trig_value,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [ADDR_W-1:0]   start_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  cwc_state_e          state_q, state_d;
  logic [SAMPLE_W-1:0] sample_q;
  logic [ADDR_W-1:0]   pretrig_l;
  logic [SAMPLE_W-1:0] mask_l, value_l;
  logic [ADDR_W-1:0]   wr_ptr, cnt;
  logic                hit;
  logic                arm_go, do_write, pre_step, hit_take, post_step;

  cwc_trig_match u_match (
    .sample (sample_q),
    .mask   (mask_l),
    .value  (value_l),
    .hit    (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    arm_go    = 1'b0;
    do_write  = 1'b0;
    pre_step  = 1'b0;
    hit_take  = 1'b0;
    post_step = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            arm_go  = 1'b1;
            state_d = (pretrig != '0) ? PRE : WAIT;
          end
        end
        PRE: begin
          do_write = 1'b1;
          pre_step = 1'b1;
          if (cnt == pretrig_l - ADDR_W'(1)) state_d = WAIT;
        end
        WAIT: begin
          do_write = 1'b1;
          if (hit) begin
            hit_take = 1'b1;
            // A full pre-trigger window leaves no room for post-trigger samples.
            state_d  = (pretrig_l == LAST_IDX) ? DONE : POST;
          end
        end
        POST: begin
          do_write  = 1'b1;
          post_step = 1'b1;
          if (cnt == ADDR_W'(1)) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q   <= '0;
      pretrig_l  <= '0;
      mask_l     <= '0;
      value_l    <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      sample_q <= {probe0, probe1, probe2};
      wr_en    <= do_write;
      if (do_write) begin
        wr_addr <= wr_ptr;
        wr_data <= sample_q;
        wr_ptr  <= wr_ptr + ADDR_W'(1);
      end
      if (arm_go) begin
        pretrig_l <= pretrig;
        mask_l    <= trig_mask;
        value_l   <= trig_value;
        wr_ptr    <= '0;
        cnt       <= '0;
      end
      if (pre_step)  cnt <= cnt + ADDR_W'(1);
      if (post_step) cnt <= cnt - ADDR_W'(1);
      if (hit_take) begin
        trig_addr  <= wr_ptr;
        start_addr <= wr_ptr - pretrig_l;
        cnt        <= LAST_IDX - pretrig_l;
      end
    end
  end

  assign busy = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
  assign done = (state_q == DONE);

endmodule
